// File: rtl/spi_fifo_drain_if.sv
// Bus bundle between the SPI FIFO drain slave and its surroundings:
// the SPI pins, the FIFO read port and the received-byte side channel.
interface spi_fifo_drain_if;
    logic        spi_sck;
    logic        spi_ss;
    logic        spi_mosi;
    logic        spi_miso;
    logic [7:0]  fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_rinc;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        underrun;
    logic [15:0] byte_count;

    modport slave (
        input  spi_sck, spi_ss, spi_mosi, fifo_rdata, fifo_rempty,
        output spi_miso, fifo_rinc, rx_data, rx_valid, underrun, byte_count
    );

    modport master (
        output spi_sck, spi_ss, spi_mosi, fifo_rdata, fifo_rempty,
        input  spi_miso, fifo_rinc, rx_data, rx_valid, underrun, byte_count
    );
endinterface

// File: rtl/spi_fifo_drain.sv
// SPI mode-0 slave: oversamples SCK/SS/MOSI, shifts FIFO bytes out on MISO
// (FILL_BYTE on underrun), deserialises MOSI and counts completed bytes.
module spi_fifo_drain #(
    parameter logic [7:0] FILL_BYTE   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    spi_fifo_drain_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   r_sck_d;
    logic                   r_ss_d;

    state_t      r_state;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_rx_shift;
    logic [2:0]  r_bit_cnt;
    logic        r_load_pending;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_underrun;
    logic        r_rinc;
    logic [15:0] r_byte_count;
    logic        r_miso;

    state_t      w_state_nxt;
    logic [7:0]  w_tx_nxt;
    logic [7:0]  w_rx_shift_nxt;
    logic [2:0]  w_bit_cnt_nxt;
    logic        w_load_pending_nxt;
    logic [7:0]  w_rx_data_nxt;
    logic        w_rx_valid_nxt;
    logic        w_underrun_nxt;
    logic        w_rinc_nxt;
    logic [15:0] w_byte_count_nxt;
    logic        w_load_req;

    logic w_sck_s, w_ss_s, w_mosi_s;
    logic w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;

    assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_ss_rise  = w_ss_s & ~r_ss_d;
    // r_fill gates out the fake SS fall seen while the chain flushes its reset value
    assign w_ss_fall  = ~w_ss_s & r_ss_d & r_fill[SYNC_STAGES];

    // Pin synchronisers, edge-detect delay and post-reset flush tracker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_fill      <= '0;
            r_sck_d     <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.spi_ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            r_fill      <= {r_fill[SYNC_STAGES-1:0], 1'b1};
            r_sck_d     <= w_sck_s;
            r_ss_d      <= w_ss_s;
        end
    end

    // FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_tx_shift     <= 8'h00;
            r_rx_shift     <= 8'h00;
            r_bit_cnt      <= 3'd0;
            r_load_pending <= 1'b0;
            r_rx_data      <= 8'h00;
            r_rx_valid     <= 1'b0;
            r_underrun     <= 1'b0;
            r_rinc         <= 1'b0;
            r_byte_count   <= 16'h0000;
            r_miso         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_tx_shift     <= w_tx_nxt;
            r_rx_shift     <= w_rx_shift_nxt;
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_load_pending <= w_load_pending_nxt;
            r_rx_data      <= w_rx_data_nxt;
            r_rx_valid     <= w_rx_valid_nxt;
            r_underrun     <= w_underrun_nxt;
            r_rinc         <= w_rinc_nxt;
            r_byte_count   <= w_byte_count_nxt;
            r_miso         <= (w_state_nxt == ST_ACTIVE) ? w_tx_nxt[7] : 1'b0;
        end
    end

    // Next-state, shift and load decisions
    always_comb begin
        w_state_nxt        = r_state;
        w_tx_nxt           = r_tx_shift;
        w_rx_shift_nxt     = r_rx_shift;
        w_bit_cnt_nxt      = r_bit_cnt;
        w_load_pending_nxt = r_load_pending;
        w_rx_data_nxt      = r_rx_data;
        w_rx_valid_nxt     = 1'b0;
        w_byte_count_nxt   = r_byte_count;
        w_underrun_nxt     = 1'b0;
        w_rinc_nxt         = 1'b0;
        w_load_req         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt        = ST_ACTIVE;
                    w_load_req         = 1'b1;
                    w_byte_count_nxt   = 16'h0000;
                    w_bit_cnt_nxt      = 3'd0;
                    w_load_pending_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_ss_rise) begin
                    w_state_nxt        = ST_IDLE;
                    w_bit_cnt_nxt      = 3'd0;
                    w_load_pending_nxt = 1'b0;
                end else if (w_sck_rise) begin
                    w_rx_shift_nxt = {r_rx_shift[6:0], w_mosi_s};
                    w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_rx_data_nxt      = {r_rx_shift[6:0], w_mosi_s};
                        w_rx_valid_nxt     = 1'b1;
                        w_load_pending_nxt = 1'b1;
                        w_byte_count_nxt   = (r_byte_count != 16'hFFFF) ?
                                             r_byte_count + 16'd1 : r_byte_count;
                    end else begin
                        w_rx_valid_nxt = 1'b0;
                    end
                end else if (w_sck_fall) begin
                    if (r_load_pending) begin
                        w_load_req         = 1'b1;
                        w_load_pending_nxt = 1'b0;
                    end else begin
                        w_tx_nxt = {r_tx_shift[6:0], 1'b0};
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_load_req) begin
            if (!bus.fifo_rempty) begin
                w_tx_nxt   = bus.fifo_rdata;
                w_rinc_nxt = 1'b1;
            end else begin
                w_tx_nxt       = FILL_BYTE;
                w_underrun_nxt = 1'b1;
            end
        end else begin
            w_rinc_nxt = 1'b0;
        end
    end

    assign bus.spi_miso   = r_miso;
    assign bus.fifo_rinc  = r_rinc;
    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.underrun   = r_underrun;
    assign bus.byte_count = r_byte_count;

endmodule
